// File: rtl/conv_arbiter.sv
// Round-robin arbiter sharing one float<->Q2.20 converter pair behind a 2-stage valid/ready pipeline.
// Optional CONV_STATS_EN builds delivered/saturated conversion counters; otherwise the stat outputs are tied to 0.
module conv_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ-1:0]     req_dir,
  input  logic [32*N_REQ-1:0]  req_data,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic                 resp_dir,
  output logic [31:0]          resp_data,
  output logic [15:0]          stat_count,
  output logic [15:0]          stat_sat
);

  localparam logic [ID_W:0]   NREQ_W = (ID_W+1)'(N_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  // IEEE-754 single -> Q2.20, truncating toward zero; |x| >= 2 (exponent bit 7 set) saturates.
  function automatic logic [21:0] fl_f(input logic [31:0] f);
    logic [7:0]  e;
    logic [21:0] mag;
    e   = f[30:23];
    mag = 22'({(e != 8'd0), f[22:0]} >> (8'd130 - e));
    if (f[30]) return 22'h200000;
    return f[31] ? (~mag + 22'd1) : mag;
  endfunction

  // Q2.20 -> IEEE-754 single; every Q2.20 value is exactly representable.
  function automatic logic [31:0] f_fl(input logic [21:0] x);
    logic [21:0] mag;
    logic [4:0]  p;
    logic [22:0] norm;
    mag = x[21] ? (~x + 22'd1) : x;
    p   = 5'd0;
    for (int b = 0; b < 22; b++) begin
      if (mag[b]) p = 5'(b);
    end
    norm = {1'b0, mag} << (5'd23 - p);
    if (mag == 22'd0) return 32'd0;
    return {x[21], 8'd107 + {3'b000, p}, norm};
  endfunction

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] grant_id;
  logic            grant_found;
  logic            grant_hs;
  logic            s1_accept;
  logic            s2_load;

  logic            s1_valid_q, s1_valid_d;
  logic            s1_dir_q, s1_dir_d;
  logic [31:0]     s1_data_q, s1_data_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;

  logic            resp_valid_q, resp_valid_d;
  logic            resp_dir_q, resp_dir_d;
  logic [31:0]     resp_data_q, resp_data_d;
  logic [ID_W-1:0] resp_id_q, resp_id_d;

  logic [21:0]     fx_res;
  logic [31:0]     fl_res;
  logic [31:0]     conv_res;

  assign s2_load   = !resp_valid_q || resp_ready;
  assign s1_accept = !s1_valid_q || s2_load;
  assign grant_hs  = grant_found && s1_accept;

  // Scan from highest offset down so the last hit is the one closest to ptr.
  always_comb begin
    logic [ID_W:0] idx;
    idx         = '0;
    grant_found = 1'b0;
    grant_id    = ptr_q;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (req_valid[idx[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = idx[ID_W-1:0];
      end
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
    assign req_ready[gi] = grant_hs && (grant_id == ID_W'(gi));
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_hs) ptr_d = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
  end

  assign fx_res   = fl_f(s1_data_q);
  assign fl_res   = f_fl(s1_data_q[21:0]);
  assign conv_res = s1_dir_q ? fl_res : {10'd0, fx_res};

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_dir_d   = s1_dir_q;
    s1_data_d  = s1_data_q;
    s1_id_d    = s1_id_q;
    if (s1_accept) begin
      s1_valid_d = grant_hs;
      if (grant_hs) begin
        s1_dir_d  = req_dir[grant_id];
        s1_data_d = req_data[32*int'(grant_id) +: 32];
        s1_id_d   = grant_id;
      end
    end
  end

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_dir_d   = resp_dir_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    if (s2_load) begin
      resp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        resp_dir_d  = s1_dir_q;
        resp_data_d = conv_res;
        resp_id_d   = s1_id_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_dir_q     <= 1'b0;
      s1_data_q    <= '0;
      s1_id_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_dir_q   <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
    end else begin
      ptr_q        <= ptr_d;
      s1_valid_q   <= s1_valid_d;
      s1_dir_q     <= s1_dir_d;
      s1_data_q    <= s1_data_d;
      s1_id_q      <= s1_id_d;
      resp_valid_q <= resp_valid_d;
      resp_dir_q   <= resp_dir_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_dir   = resp_dir_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;

`ifdef CONV_STATS_EN
  logic        sat_q, sat_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] satcnt_q, satcnt_d;
  logic        resp_hs;

  assign resp_hs = resp_valid_q && resp_ready;

  always_comb begin
    sat_d    = sat_q;
    cnt_d    = cnt_q;
    satcnt_d = satcnt_q;
    if (s2_load && s1_valid_q) sat_d = !s1_dir_q && s1_data_q[30];
    if (resp_hs && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    if (resp_hs && sat_q && satcnt_q != 16'hFFFF) satcnt_d = satcnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q    <= 1'b0;
      cnt_q    <= '0;
      satcnt_q <= '0;
    end else begin
      sat_q    <= sat_d;
      cnt_q    <= cnt_d;
      satcnt_q <= satcnt_d;
    end
  end

  assign stat_count = cnt_q;
  assign stat_sat   = satcnt_q;
`else
  assign stat_count = 16'd0;
  assign stat_sat   = 16'd0;
`endif

endmodule

// File: tb/tb_conv_arbiter.sv
// Scoreboard bench for conv_arbiter: random requesters, real-arithmetic conversion model, RR and occupancy model.
module tb_conv_arbiter;
  localparam int N = 4;
  localparam int IDW = 2;
`ifdef CONV_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_dir = '0;
  logic [32*N-1:0] req_data = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [IDW-1:0]  resp_id;
  logic            resp_dir;
  logic [31:0]     resp_data;
  logic [15:0]     stat_count;
  logic [15:0]     stat_sat;

  conv_arbiter #(.N_REQ(N), .ID_W(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_dir(resp_dir), .resp_data(resp_data),
    .stat_count(stat_count), .stat_sat(stat_sat)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic dir; logic [31:0] data; logic sat; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int m_ptr = 0;
  int accepted = 0;
  int delivered = 0;
  int delivered_sat = 0;
  int refill_pct = 0;
  int ready_pct = 100;

  logic [N-1:0] pv = '0;
  logic [N-1:0] pd = '0;
  logic [31:0]  pdata [N];
  logic [31:0]  pexp [N];
  logic [N-1:0] pexp_v = '0;
  logic [N-1:0] hs_n = '0;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  int          prev_id;
  logic        prev_dir;

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [21:0] m_fl_f(logic [31:0] f);
    logic [63:0] b;
    int ex, n;
    if (f[30]) return 22'h200000;
    if (f[30:23] == 8'd0) return 22'd0;
    ex = int'(f[30:23]) + 896;
    b  = {f[31], ex[10:0], f[22:0], 29'd0};
    n  = $rtoi($bitstoreal(b) * 1048576.0);
    return n[21:0];
  endfunction

  function automatic logic [31:0] m_f_fl(logic [21:0] x);
    logic [63:0] b;
    int n, e;
    n = x[21] ? int'(x) - 4194304 : int'(x);
    if (n == 0) return 32'd0;
    b = $realtobits(real'(n) / 1048576.0);
    e = int'(b[62:52]) - 1023 + 127;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  // Monitor: request-side prediction and response-side scoreboard pop.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [N-1:0] expv;
      int g;
      exp_t e;
      expv = '0;
      g = -1;
      if (req_valid != '0 && (sb.size() < 2 || resp_ready)) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        expv[g] = 1'b1;
      end
      chk("req_ready", 32'(req_ready), 32'(expv));
      chk("stat_count", 32'(stat_count), STATS ? delivered : 0);
      chk("stat_sat", 32'(stat_sat), STATS ? delivered_sat : 0);

      if (prev_stall) begin
        chk("stall_valid", 32'(resp_valid), 1);
        chk("stall_data", resp_data, prev_data);
        chk("stall_id", 32'(resp_id), prev_id);
        chk("stall_dir", 32'(resp_dir), 32'(prev_dir));
      end
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          chk("resp_unexpected", 32'(resp_valid), 0);
        end else begin
          e = sb.pop_front();
          chk("resp_id", 32'(resp_id), e.id);
          chk("resp_dir", 32'(resp_dir), 32'(e.dir));
          chk("resp_data", resp_data, e.data);
          delivered++;
          if (e.sat) delivered_sat++;
        end
      end
      prev_stall = resp_valid && !resp_ready;
      prev_data  = resp_data;
      prev_id    = int'(resp_id);
      prev_dir   = resp_dir;

      hs_n = req_valid & req_ready;
      for (int i = 0; i < N; i++) begin
        if (hs_n[i]) begin
          e.id  = i;
          e.dir = req_dir[i];
          if (pexp_v[i]) e.data = pexp[i];
          else if (req_dir[i]) e.data = m_f_fl(req_data[32*i +: 22]);
          else e.data = {10'd0, m_fl_f(req_data[32*i +: 32])};
          e.sat = !req_dir[i] && req_data[32*i+30];
          sb.push_back(e);
          accepted++;
          m_ptr = (i + 1) % N;
        end
      end
    end
  end

  task automatic new_req(int i);
    logic [7:0] ex;
    pd[i] = 1'($urandom_range(1));
    ex = 8'($urandom_range(100, 135));
    if (!pd[i]) pdata[i] = {1'($urandom_range(1)), ex, 23'($urandom)};
    else pdata[i] = $urandom;
    pexp_v[i] = 1'b0;
    pv[i] = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs_n[i]) begin
        pv[i] = 1'b0;
        pexp_v[i] = 1'b0;
      end
      if (!pv[i] && $urandom_range(99) < refill_pct) new_req(i);
    end
    resp_ready = ($urandom_range(99) < ready_pct);
    req_valid = pv;
    req_dir = pd;
    for (int i = 0; i < N; i++) req_data[32*i +: 32] = pdata[i];
  endtask

  task automatic issue(int i, logic d, logic [31:0] data, logic [31:0] expv);
    pv[i] = 1'b1; pd[i] = d; pdata[i] = data; pexp[i] = expv; pexp_v[i] = 1'b1;
    for (int t = 0; t < 30 && pv[i]; t++) step();
    chk("issue_timeout", 32'(pv[i]), 0);
  endtask

  task automatic drain();
    for (int t = 0; t < 80 && (sb.size() != 0 || resp_valid || pv != '0); t++) step();
    chk("drain_empty", 32'(sb.size()), 0);
  endtask

  task automatic clear_model();
    sb.delete();
    hs_n = '0;
    m_ptr = 0;
    delivered = 0;
    delivered_sat = 0;
    prev_stall = 1'b0;
  endtask

  initial begin
    int a0, d0;
    for (int i = 0; i < N; i++) begin pdata[i] = '0; pexp[i] = '0; end
    #12;
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_id", 32'(resp_id), 0);
    chk("rst_resp_dir", 32'(resp_dir), 0);
    chk("rst_stat_count", 32'(stat_count), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Latency: handshake at edge k, resp_valid after edge k+1.
    refill_pct = 0; ready_pct = 100;
    pv[0] = 1'b1; pd[0] = 1'b0; pdata[0] = 32'h3F800000; pexp[0] = 32'h00100000; pexp_v[0] = 1'b1;
    step();
    step();
    chk("lat_after_k", 32'(resp_valid), 0);
    step();
    chk("lat_after_k1", 32'(resp_valid), 1);
    chk("lat_data", resp_data, 32'h00100000);
    chk("lat_id", 32'(resp_id), 0);

    issue(1, 1'b0, 32'hBF800000, 32'h00300000);
    issue(2, 1'b1, 32'h00080000, 32'h3F000000);
    issue(3, 1'b1, 32'h00200000, 32'hC0000000);
    issue(0, 1'b0, 32'h40000000, 32'h00200000);
    issue(1, 1'b0, 32'h7F800000, 32'h00200000);
    issue(2, 1'b0, 32'hC0400000, 32'h00200000);
    issue(3, 1'b0, 32'h3E800000, 32'h00040000);
    issue(0, 1'b1, 32'hFF3C0000, 32'hBE800000);
    issue(1, 1'b1, 32'hABC00000, 32'h00000000);
    drain();
    step();
    chk("stats_count10", 32'(stat_count), STATS ? 10 : 0);
    chk("stats_sat3", 32'(stat_sat), STATS ? 3 : 0);

    // Full throughput with all requesters valid.
    refill_pct = 100; ready_pct = 100;
    repeat (4) step();
    a0 = accepted;
    repeat (12) step();
    chk("throughput", 32'(accepted - a0), 12);
    refill_pct = 0;
    drain();

    // Stall: only S1 and S2 may fill.
    ready_pct = 0;
    a0 = accepted; d0 = delivered;
    for (int i = 0; i < 3; i++) new_req(i);
    step();
    repeat (5) step();
    chk("stall_accepts", 32'(accepted - a0), 2);
    ready_pct = 100;
    drain();
    chk("stall_drain", 32'(delivered - d0), 3);

    // Asynchronous reset with both stages full.
    refill_pct = 100; ready_pct = 0;
    for (int t = 0; t < 20 && sb.size() < 2; t++) step();
    chk("pre_rst_full", 32'(sb.size()), 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    clear_model();
    #1;
    chk("async_rst_valid", 32'(resp_valid), 0);
    chk("async_rst_data", resp_data, 0);
    refill_pct = 0; ready_pct = 100;
    pv = 4'b1010;
    pexp_v = '0;
    step();
    #2 rst_n = 1'b1;
    #1;
    chk("post_rst_grant", 32'(req_ready), 32'h2);
    drain();

    // Randomised traffic with random backpressure.
    for (int phase = 0; phase < 4; phase++) begin
      refill_pct = 30 + 20 * phase;
      ready_pct = 90 - 20 * phase;
      repeat (100) step();
    end
    refill_pct = 0; ready_pct = 100;
    drain();
    step();
    chk("final_stat_count", 32'(stat_count), STATS ? delivered : 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
